adc_sensor_conditioner: RTL

- Sits directly downstream of the SPI ADC controller.
- Consumes the free-running 8-bit accel-pedal (CH0) and CDS light-sensor (CH1) codes.
- Samples both codes at a fixed rate and box-car averages them over 2^AVG_LOG2 samples.
- Produces a dead-zoned throttle level for the vehicle model and a debounced, hysteretic night flag for headlight control.

---
 rtl/sensor_pkg.sv | 18 +
 rtl/hyst_debounce.sv | 52 +++++
 rtl/adc_sensor_conditioner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared types and defaults for the ADC sensor conditioning path.
package sensor_pkg;
  localparam int ADC_W            = 8;
  localparam int DEF_SAMPLE_DIV   = 50000;
  localparam int DEF_AVG_LOG2     = 3;
  localparam int DEF_DEADZONE     = 8;
  localparam int DEF_NIGHT_ON_TH  = 60;
  localparam int DEF_NIGHT_OFF_TH = 90;
  localparam int DEF_DEBOUNCE     = 4;

  typedef enum logic {S_ACC = 1'b0, S_EVAL = 1'b1} state_e;

  // Levels at or below dz collapse to zero; anything above is shifted down.
  function automatic logic [ADC_W-1:0] dead_zone(input logic [ADC_W-1:0] v,
                                                 input logic [ADC_W-1:0] dz);
    return (v <= dz) ? '0 : v - dz;
  endfunction
endpackage

// File: rtl/hyst_debounce.sv
// Two-threshold debounced flag: sets after DEBOUNCE updates below ON_TH,
// clears after DEBOUNCE updates above OFF_TH; a non-qualifying update restarts the count.
module hyst_debounce #(
  parameter int W        = 8,
  parameter int ON_TH    = 60,
  parameter int OFF_TH   = 90,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd_i,
  input  logic [W-1:0] level_i,
  output logic         flag_o
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [W-1:0]  ON_V     = W'(ON_TH);
  localparam logic [W-1:0]  OFF_V    = W'(OFF_TH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qualify;

  assign qualify = flag_q ? (level_i > OFF_V) : (level_i < ON_V);

  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (upd_i) begin
      if (!qualify) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        flag_d = ~flag_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag_o = flag_q;
endmodule

// File: rtl/adc_sensor_conditioner.sv
// Ticked box-car averaging of pedal and light-sensor ADC codes, producing a
// dead-zoned throttle level and a debounced hysteretic night flag.
module adc_sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int AVG_LOG2     = DEF_AVG_LOG2,
  parameter int DEADZONE     = DEF_DEADZONE,
  parameter int NIGHT_ON_TH  = DEF_NIGHT_ON_TH,
  parameter int NIGHT_OFF_TH = DEF_NIGHT_OFF_TH,
  parameter int DEBOUNCE     = DEF_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ADC_W-1:0] adc_accel,
  input  logic [ADC_W-1:0] adc_cds,
  output logic [ADC_W-1:0] accel_avg,
  output logic [ADC_W-1:0] cds_avg,
  output logic [ADC_W-1:0] throttle,
  output logic             pedal_pressed,
  output logic             night_mode,
  output logic             avg_valid
);
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int SUM_W  = ADC_W + AVG_LOG2;
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]  SMP_LAST  = CNT_W'(NSAMP - 1);
  localparam logic [ADC_W-1:0]  DZ        = ADC_W'(DEADZONE);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [SUM_W-1:0]  accel_sum_q, accel_sum_d, cds_sum_q, cds_sum_d;
  logic [ADC_W-1:0]  accel_avg_q, cds_avg_q, throttle_q;
  logic              pedal_q, avg_valid_q;
  logic              tick, last_smp, acc_en, eval;
  logic [ADC_W-1:0]  accel_avg_new, cds_avg_new, throttle_new;

  assign tick     = en && (tick_cnt_q == TICK_LAST);
  assign last_smp = (sample_cnt_q == SMP_LAST);

  // FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (tick && last_smp) state_d = S_EVAL;
      S_EVAL:  state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_comb begin
    acc_en = 1'b0;
    eval   = 1'b0;
    case (state_q)
      S_ACC:   acc_en = tick;
      S_EVAL:  eval   = 1'b1;
      default: ;
    endcase
  end

  // The final sample is folded into the sums so EVAL sees complete totals.
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    sample_cnt_d = sample_cnt_q;
    accel_sum_d  = accel_sum_q;
    cds_sum_d    = cds_sum_q;
    if (en) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    if (acc_en) begin
      accel_sum_d  = accel_sum_q + SUM_W'(adc_accel);
      cds_sum_d    = cds_sum_q + SUM_W'(adc_cds);
      sample_cnt_d = last_smp ? '0 : sample_cnt_q + 1'b1;
    end else if (eval) begin
      accel_sum_d = '0;
      cds_sum_d   = '0;
    end
  end

  assign accel_avg_new = ADC_W'(accel_sum_q >> AVG_LOG2);
  assign cds_avg_new   = ADC_W'(cds_sum_q >> AVG_LOG2);
  assign throttle_new  = dead_zone(accel_avg_new, DZ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      accel_sum_q  <= '0;
      cds_sum_q    <= '0;
      accel_avg_q  <= '0;
      cds_avg_q    <= '0;
      throttle_q   <= '0;
      pedal_q      <= 1'b0;
      avg_valid_q  <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      accel_sum_q  <= accel_sum_d;
      cds_sum_q    <= cds_sum_d;
      avg_valid_q  <= eval;
      if (eval) begin
        accel_avg_q <= accel_avg_new;
        cds_avg_q   <= cds_avg_new;
        throttle_q  <= throttle_new;
        pedal_q     <= (throttle_new != '0);
      end
    end
  end

  hyst_debounce #(
    .W(ADC_W), .ON_TH(NIGHT_ON_TH), .OFF_TH(NIGHT_OFF_TH), .DEBOUNCE(DEBOUNCE)
  ) u_night (
    .clk     (clk),
    .rst     (rst),
    .upd_i   (eval),
    .level_i (cds_avg_new),
    .flag_o  (night_mode)
  );

  assign accel_avg     = accel_avg_q;
  assign cds_avg       = cds_avg_q;
  assign throttle      = throttle_q;
  assign pedal_pressed = pedal_q;
  assign avg_valid     = avg_valid_q;
endmodule
